// File: rtl/dma_xfer_ctrl_pkg.sv
// rtl/dma_xfer_ctrl_pkg.sv - shared types and constants for the DMA transfer sequencer
//
// Purpose : state encoding, default word-count width and descriptor record
//           used by dma_xfer_ctrl and its bus interface.
// Ports   : none (package).
`include "global_para.svh"

package dma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  localparam int LEN_W_DEFAULT = 16;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0]  src;
    logic [`ADDR_WIDTH-1:0]  dst;
    logic [LEN_W_DEFAULT-1:0] len;
  } dma_desc_t;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// rtl/dma_xfer_ctrl_if.sv - DMA memory-side bus interface
//
// Purpose : bundles the single-master memory port driven by dma_xfer_ctrl.
// Signals : addr (word address), wdata (write data), wr_en / rd_en (strobes),
//           rdata (read data, valid the cycle after rd_en).
// Modports: master - the DMA sequencer; slave - the memory.
`include "global_para.svh"

interface dma_xfer_ctrl_if #(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ADDR_W = `ADDR_WIDTH
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic              rd_en;

  modport master (output addr, output wdata, output wr_en, output rd_en, input rdata);
  modport slave  (input addr, input wdata, input wr_en, input rd_en, output rdata);

endinterface

// File: rtl/global_para.svh
// rtl/global_para.svh - shared bus width macros for the DMA memory port
`ifndef GLOBAL_PARA_SVH
`define GLOBAL_PARA_SVH

`define DATA_WIDTH 32
`define ADDR_WIDTH 8

`endif

// File: rtl/dma_xfer_ctrl.sv
// rtl/dma_xfer_ctrl.sv - single-channel DMA transfer sequencer (read, capture, write per word)
//
// Purpose : accepts one descriptor (src, dst, len) when ready and copies len
//           words in ascending order, one word every three cycles, then
//           pulses done for one cycle.
// Ports   : clk, rst (async, active-high)
//           start, src_addr, dst_addr, len - descriptor handshake (accepted on start && ready)
//           ready, busy, done, words_done   - status
//           bus (dma_xfer_ctrl_if.master)   - memory port: addr, wdata, wr_en, rd_en, rdata
// Option  : DMA_ABORT_EN adds input abort and sticky output aborted.
`include "global_para.svh"

module dma_xfer_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef DMA_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  dma_xfer_ctrl_if.master   bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_RD   = ST_RD;
  localparam logic [2:0] S_CAP  = ST_CAP;
  localparam logic [2:0] S_WR   = ST_WR;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] hold;
  logic              abort_hit;

`ifdef DMA_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Status and strobes are pure decodes of the state register.
  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_RD) || (state == S_CAP) || (state == S_WR) || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign bus.rd_en = (state == S_RD);
  assign bus.wr_en = (state == S_WR);
  // addr is loaded one edge ahead of the strobe and simply holds otherwise;
  // the holding register doubles as the write-data output.
  assign bus.addr  = addr_q;
  assign bus.wdata = hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      addr_q     <= '0;
      remaining  <= '0;
      hold       <= '0;
      words_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_src    <= src_addr;
            cur_dst    <= dst_addr;
            remaining  <= len;
            words_done <= '0;
            if (len != '0) begin
              state  <= S_RD;
              addr_q <= src_addr;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RD: begin
          state <= abort_hit ? S_DONE : S_CAP;
        end
        S_CAP: begin
          // An abort here drops the word, so wdata keeps its previous value.
          if (abort_hit) begin
            state <= S_DONE;
          end else begin
            hold   <= bus.rdata;
            addr_q <= cur_dst;
            state  <= S_WR;
          end
        end
        S_WR: begin
          cur_src    <= cur_src + ADDR_W'(1);
          cur_dst    <= cur_dst + ADDR_W'(1);
          words_done <= words_done + LEN_W'(1);
          remaining  <= remaining - LEN_W'(1);
          if ((remaining == LEN_W'(1)) || abort_hit) begin
            state <= S_DONE;
          end else begin
            addr_q <= cur_src + ADDR_W'(1);
            state  <= S_RD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DMA_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      aborted <= 1'b0;
    end else if (abort && ((state == S_RD) || (state == S_CAP) || (state == S_WR))) begin
      aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb/tb_dma_xfer_ctrl.sv - self-checking bench for dma_xfer_ctrl
`timescale 1ns/1ps

module tb_dma_xfer_ctrl;

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [15:0] len;
    int          exp_done;
    int          exp_words;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [15:0] len;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] words_done;
`ifdef DMA_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  dma_xfer_ctrl_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  dma_xfer_ctrl #(.DATA_W(32), .ADDR_W(8), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef DMA_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and bus log
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  logic [7:0]  rd_log  [16];
  int          rd_cnt;
  int          wr_cnt;
  int          both_err;
  logic        load_mem;
  logic        clr_log;

  function automatic logic [31:0] init_val(int i);
    return 32'hA000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      both_err = 0;
    end
    if (clr_log) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (bus.rd_en) begin
      bus.rdata <= mem[bus.addr];
      if (rd_cnt < 16) rd_log[rd_cnt] = bus.addr;
      rd_cnt++;
    end
    if (bus.wr_en) begin
      mem[bus.addr] <= bus.wdata;
      wr_cnt++;
    end
    if (bus.rd_en && bus.wr_en) both_err++;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic shadow_copy(input logic [7:0] s, input logic [7:0] d, input int l);
    logic [7:0] sa;
    logic [7:0] da;
    sa = s;
    da = d;
    for (int i = 0; i < l; i++) begin
      exp_mem[da] = exp_mem[sa];
      sa++;
      da++;
    end
  endtask

  task automatic mem_compare(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Drives a descriptor across one accept edge and returns 1 ns after it;
  // the next negedge is then cycle k+1. Inputs are scrambled after the edge.
  task automatic accept(input logic [7:0] s, input logic [7:0] d, input logic [15:0] l);
    @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = l;
    clr_log  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    clr_log  = 1'b0;
    src_addr = 8'h77;
    dst_addr = 8'h99;
    len      = 16'd7;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         perr;
    int         done_n;
    bit         got;
    int         w;
    int         ph;
    logic [7:0] ea;
    perr   = 0;
    done_n = -1;
    got    = 1'b0;
    shadow_copy(v.src, v.dst, int'(v.len));
    accept(v.src, v.dst, v.len);
    for (int n = 1; n <= 200 && !got; n++) begin
      @(negedge clk);
      if (n <= 3 * int'(v.len)) begin
        w  = (n - 1) / 3;
        ph = (n - 1) % 3;
        if (bus.rd_en !== (ph == 0) || bus.wr_en !== (ph == 2) || done !== 1'b0 || busy !== 1'b1) perr++;
        if (ph == 0) begin
          ea = v.src + 8'(w);
          if (bus.addr !== ea) perr++;
        end
        if (ph == 2) begin
          ea = v.dst + 8'(w);
          if (bus.addr !== ea) perr++;
        end
      end
      if (done) begin
        got    = 1'b1;
        done_n = n;
      end
    end
    check($sformatf("vec%0d_done_cycle", idx), done_n, v.exp_done);
    check($sformatf("vec%0d_protocol", idx), perr, 0);
    check($sformatf("vec%0d_writes", idx), wr_cnt, v.exp_words);
    check($sformatf("vec%0d_reads", idx), rd_cnt, v.exp_words);
    check($sformatf("vec%0d_words_done", idx), words_done, v.exp_words);
    @(negedge clk);
    check($sformatf("vec%0d_ready_after", idx), ready, 1);
    check($sformatf("vec%0d_done_one_cycle", idx), done, 0);
    mem_compare($sformatf("vec%0d_memory", idx));
  endtask

  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected self-termination");
    $fatal(1);
  end

  initial begin
    int   done_n;
    bit   got;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{src: 8'h10, dst: 8'h40, len: 16'd4, exp_done: 13, exp_words: 4};
    vecs[1] = '{src: 8'h20, dst: 8'h60, len: 16'd0, exp_done: 1,  exp_words: 0};
    vecs[2] = '{src: 8'h05, dst: 8'h80, len: 16'd1, exp_done: 4,  exp_words: 1};
    vecs[3] = '{src: 8'h30, dst: 8'h31, len: 16'd3, exp_done: 10, exp_words: 3};

    rst      = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    load_mem = 1'b1;
    clr_log  = 1'b1;
`ifdef DMA_ABORT_EN
    abort    = 1'b0;
`endif
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

    // Reset / idle
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_words_done", words_done, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    load_mem = 1'b0;
    clr_log  = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    check("idle_strobes", {bus.rd_en, bus.wr_en}, 0);

    // Table-driven descriptors: basic, zero length, single word, overlapping
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Address wrap with a start pulsed while busy
    shadow_copy(8'hFE, 8'hA0, 3);
    accept(8'hFE, 8'hA0, 16'd3);
    got    = 1'b0;
    done_n = -1;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got    = 1'b1;
        done_n = n;
      end
      if (n == 4) begin
        start    = 1'b1;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        len      = 16'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("wrap_done_cycle", done_n, 10);
    check("wrap_rd0", rd_log[0], 8'hFE);
    check("wrap_rd1", rd_log[1], 8'hFF);
    check("wrap_rd2", rd_log[2], 8'h00);
    repeat (6) @(negedge clk);
    check("wrap_ignored_start_writes", wr_cnt, 3);
    check("wrap_ignored_start_reads", rd_cnt, 3);
    check("wrap_ready", ready, 1);
    mem_compare("wrap_memory");

    // Reset during the WR of word 2 of a five-word copy
    shadow_copy(8'h50, 8'hC0, 2);
    accept(8'h50, 8'hC0, 16'd5);
    repeat (9) @(negedge clk);
    check("midrst_in_wr", bus.wr_en, 1);
    check("midrst_wr_addr", bus.addr, 8'hC2);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_strobes", {bus.rd_en, bus.wr_en}, 0);
    check("midrst_addr", bus.addr, 0);
    check("midrst_wdata", bus.wdata, 0);
    check("midrst_words_done", words_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_writes", wr_cnt, 2);
    mem_compare("midrst_memory");

`ifdef DMA_ABORT_EN
    // Abort in the CAP of word 3 of an eight-word copy
    shadow_copy(8'h00, 8'hE0, 3);
    accept(8'h00, 8'hE0, 16'd8);
    got    = 1'b0;
    done_n = -1;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got    = 1'b1;
        done_n = n;
      end
      abort = (n == 11);
    end
    abort = 1'b0;
    check("abort_done_cycle", done_n, 12);
    check("abort_writes", wr_cnt, 3);
    check("abort_words_done", words_done, 3);
    check("abort_flag", aborted, 1);
    mem_compare("abort_memory");
    @(negedge clk);
    accept(8'h00, 8'h00, 16'd0);
    check("abort_clear_on_accept", aborted, 0);
    repeat (3) @(negedge clk);
`endif

    check("rd_wr_never_together", both_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
